// File: rtl/reg_bank.sv
// General-register bank on the shared tri-state data bus: indexed load/assert,
// in-place increment/decrement with carry/borrow and zero flags, sticky bus-error flag.
module reg_bank #(
  parameter int               WIDTH       = 8,
  parameter int               NREGS       = 4,
  parameter int               IDXW        = 2,
  parameter logic [NREGS-1:0] ASSERT_MASK = 4'b1001
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_en,
  input  logic [IDXW-1:0]        load_sel,
  input  logic                   assert_en,
  input  logic [IDXW-1:0]        assert_sel,
  input  logic                   inc_en,
  input  logic                   dec_en,
  input  logic [IDXW-1:0]        cnt_sel,
  inout  wire  [WIDTH-1:0]       dbus,
  output logic [NREGS*WIDTH-1:0] regs_flat,
  output logic                   zero,
  output logic                   carry,
  output logic                   bus_err
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             carry_q, carry_d;
  logic             bus_err_q, bus_err_d;

  logic [WIDTH-1:0] asrt_val, cnt_val;
  logic             mask_ok, assert_ok, drive;
  logic             load_go, cnt_go, cnt_blocked;

  function automatic logic in_range(input logic [IDXW-1:0] idx);
    return 32'(idx) < 32'(NREGS);
  endfunction

  // Source/counter selection by compare so no index ever exceeds the array.
  always_comb begin
    asrt_val = '0;
    cnt_val  = '0;
    mask_ok  = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (assert_sel == IDXW'(i)) begin
        asrt_val = regs_q[i];
        mask_ok  = ASSERT_MASK[i];
      end
      if (cnt_sel == IDXW'(i)) cnt_val = regs_q[i];
    end
  end

  assign assert_ok = assert_en && in_range(assert_sel) && mask_ok;
  assign drive     = assert_ok && !reset;
  assign dbus      = drive ? asrt_val : 'z;

  assign load_go     = load_en && in_range(load_sel);
  assign cnt_go      = (inc_en ^ dec_en) && in_range(cnt_sel);
  assign cnt_blocked = load_go && (load_sel == cnt_sel);

  // Load takes priority over a count aimed at the same register.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NREGS; i++) begin
      if (load_go && load_sel == IDXW'(i))
        regs_d[i] = dbus;
      else if (cnt_go && cnt_sel == IDXW'(i))
        regs_d[i] = inc_en ? regs_q[i] + WIDTH'(1) : regs_q[i] - WIDTH'(1);
    end
  end

  always_comb begin
    carry_d = carry_q;
    if (cnt_go && !cnt_blocked)
      carry_d = inc_en ? (cnt_val == '1) : (cnt_val == '0);
  end

  assign bus_err_d = bus_err_q | (assert_en && !assert_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      carry_q   <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      carry_q   <= carry_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NREGS; i++) regs_flat[i*WIDTH +: WIDTH] = regs_q[i];
  end

  assign zero    = (cnt_val == '0);
  assign carry   = carry_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: reset, load/assert, wrap, priority, illegal assert, self-transfer.
module tb_reg_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en, assert_en, inc_en, dec_en;
  logic [1:0]  load_sel, assert_sel, cnt_sel;
  wire  [7:0]  dbus;
  logic [31:0] regs_flat;
  logic        zero, carry, bus_err;

  logic        tb_drv_en;
  logic [7:0]  tb_drv;
  int          n_chk  = 0;
  int          n_fail = 0;

  assign dbus = tb_drv_en ? tb_drv : 'z;

  always #5 clk = ~clk;

  reg_bank dut (
    .clk(clk), .reset(reset),
    .load_en(load_en), .load_sel(load_sel),
    .assert_en(assert_en), .assert_sel(assert_sel),
    .inc_en(inc_en), .dec_en(dec_en), .cnt_sel(cnt_sel),
    .dbus(dbus), .regs_flat(regs_flat),
    .zero(zero), .carry(carry), .bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load_en = 0; assert_en = 0; inc_en = 0; dec_en = 0;
    load_sel = 0; assert_sel = 0; cnt_sel = 0;
    tb_drv_en = 0; tb_drv = 8'h00;
  endtask

  task automatic load(input logic [1:0] idx, input logic [7:0] val);
    load_en = 1; load_sel = idx; tb_drv_en = 1; tb_drv = val;
    tick();
    idle();
  endtask

  // DUT must not drive: bench drives 8'h00 and expects it back unchanged.
  task automatic check_released(input string tag);
    tb_drv_en = 1; tb_drv = 8'h00;
    #1;
    check(tag, {24'h0, dbus}, 32'h0);
    tb_drv_en = 0;
  endtask

  function automatic logic [7:0] reg_of(input int i);
    return regs_flat[i*8 +: 8];
  endfunction

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;

    // 1. reset clears regs, carry, bus_err and releases dbus
    load(2'd1, 8'h5A);
    check("load_r1", {24'h0, reg_of(1)}, 32'h5A);
    load(2'd0, 8'h3C);
    dec_en = 1; cnt_sel = 2; tick(); idle();
    check("pre_rst_carry", {31'h0, carry}, 32'h1);
    assert_en = 1; assert_sel = 1;
    check_released("illegal_dbus_r1");
    tick(); idle();
    check("pre_rst_buserr", {31'h0, bus_err}, 32'h1);
    reset = 1; assert_en = 1; assert_sel = 0;
    check_released("rst_dbus");
    tick();
    reset = 0; idle();
    check("rst_regs", regs_flat, 32'h0);
    check("rst_carry", {31'h0, carry}, 32'h0);
    check("rst_buserr", {31'h0, bus_err}, 32'h0);

    // 2. load then assert
    load(2'd0, 8'h3C);
    assert_en = 1; assert_sel = 0; #1;
    check("asrt_r0", {24'h0, dbus}, 32'h3C);
    assert_sel = 3; #1;
    check("asrt_r3", {24'h0, dbus}, 32'h00);
    tick(); idle();
    check("legal_no_err", {31'h0, bus_err}, 32'h0);

    // 3. increment wrap and decrement borrow
    load(2'd3, 8'hFE);
    inc_en = 1; cnt_sel = 3; tick();
    check("inc1_r3", {24'h0, reg_of(3)}, 32'hFF);
    check("inc1_carry", {31'h0, carry}, 32'h0);
    check("inc1_zero", {31'h0, zero}, 32'h0);
    tick();
    check("inc2_r3", {24'h0, reg_of(3)}, 32'h00);
    check("inc2_carry", {31'h0, carry}, 32'h1);
    check("inc2_zero", {31'h0, zero}, 32'h1);
    inc_en = 0; dec_en = 1; tick();
    check("dec_r3", {24'h0, reg_of(3)}, 32'hFF);
    check("dec_carry", {31'h0, carry}, 32'h1);
    check("dec_zero", {31'h0, zero}, 32'h0);
    idle(); tick();
    check("carry_hold", {31'h0, carry}, 32'h1);

    // 4. load beats count; inc+dec is a no-op; different indices both act
    load(2'd2, 8'h10);
    load_en = 1; load_sel = 2; tb_drv_en = 1; tb_drv = 8'h77;
    inc_en = 1; cnt_sel = 2; tick(); idle();
    check("prio_r2", {24'h0, reg_of(2)}, 32'h77);
    check("prio_carry", {31'h0, carry}, 32'h1);
    inc_en = 1; dec_en = 1; cnt_sel = 2; tick(); idle();
    check("incdec_r2", {24'h0, reg_of(2)}, 32'h77);
    check("incdec_carry", {31'h0, carry}, 32'h1);
    load_en = 1; load_sel = 0; tb_drv_en = 1; tb_drv = 8'h11;
    inc_en = 1; cnt_sel = 1; tick(); idle();
    check("dual_r0", {24'h0, reg_of(0)}, 32'h11);
    check("dual_r1", {24'h0, reg_of(1)}, 32'h01);
    check("dual_carry", {31'h0, carry}, 32'h0);

    // 5. illegal assert sets sticky bus_err
    assert_en = 1; assert_sel = 1;
    check_released("illegal_dbus");
    check("illegal_err_pre", {31'h0, bus_err}, 32'h0);
    tick();
    check("illegal_err", {31'h0, bus_err}, 32'h1);
    assert_sel = 0; #1;
    check("legal_after_err_dbus", {24'h0, dbus}, 32'h11);
    tick(); idle(); tick();
    check("err_sticky", {31'h0, bus_err}, 32'h1);
    reset = 1; tick(); reset = 0;
    check("err_cleared", {31'h0, bus_err}, 32'h0);

    // 6. self-transfer leaves the register unchanged
    load(2'd0, 8'hA5);
    assert_en = 1; assert_sel = 0; load_en = 1; load_sel = 0;
    tick(); idle();
    check("self_xfer_r0", {24'h0, reg_of(0)}, 32'hA5);
    check("self_xfer_err", {31'h0, bus_err}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
